// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_pkg
//  Description : Shared operation codes, FSM state encoding and iteration
//                constants for the HI/LO multiply unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package hilo_pkg;

  // One shift-add step per operand bit at the default 32-bit width
  localparam int MUL_CYCLES = 32;
  localparam int CNT_W      = 6;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Every 0xx encoding is a multiply variant
  function automatic logic is_mul_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // MULTU is the only multiply working on raw unsigned operands
  function automatic logic is_signed_op(input logic [2:0] op);
    return is_mul_op(op) && (op != OP_MULTU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_iter_dp.sv
`default_nettype none
// ============================================================================
//  Module      : mult_iter_dp
//  Description : Iterative radix-2 shift-add multiplier datapath. Converts
//                operands to magnitudes on load, forms one partial product
//                per step, and applies the sign fix on the output.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_iter_dp #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   a_mag, b_mag, addend;
  logic [WIDTH:0]     upper_sum;

  // Magnitude conversion on load, one add-and-shift per step otherwise
  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    neg_d   = neg_q;
    // -MIN wraps to itself, which is the correct unsigned magnitude
    a_mag     = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    b_mag     = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    addend    = prod_q[0] ? mcand_q : '0;
    upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    if (i_load) begin
      mcand_d = a_mag;
      prod_d  = {{WIDTH{1'b0}}, b_mag};
      neg_d   = i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    end else if (i_step) begin
      // Multiplier bits are consumed from the low half as the sum shifts in
      prod_d = {upper_sum, prod_q[WIDTH-1:1]};
    end
  end

  // Working registers, cleared on reset so an aborted multiply leaves nothing behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      neg_q   <= neg_d;
    end
  end

  assign o_product = neg_q ? -prod_q : prod_q;

endmodule
`default_nettype wire

// File: rtl/hilo_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_mult_unit
//  Description : MIPS-style HI/LO unit. Sequences iterative MULT/MULTU/
//                MADD/MSUB through an IDLE/MUL/ACC/DONE FSM and services
//                single-cycle MTHI/MTLO writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_mult_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dp_load, dp_step;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] acc_result;

  mult_iter_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk       (Clk),
    .rst       (Rst),
    .i_load    (dp_load),
    .i_step    (dp_step),
    .i_signed  (is_signed_op(Op)),
    .i_a       (A),
    .i_b       (B),
    .o_product (product)
  );

  // Next-state, HI/LO update and datapath control
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    acc_result = product;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE is a one-cycle pulse; new work may be accepted in the same cycle
        state_d = ST_IDLE;
        if (Start) begin
          if (is_mul_op(Op)) begin
            op_d    = Op;
            cnt_d   = '0;
            dp_load = 1'b1;
            state_d = ST_MUL;
          end else if (Op == OP_MTHI) begin
            hi_d = A;
          end else if (Op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_MUL: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        case (op_q)
          OP_MADD: acc_result = {hi_q, lo_q} + product;
          OP_MSUB: acc_result = {hi_q, lo_q} - product;
          default: acc_result = product;
        endcase
        {hi_d, lo_d} = acc_result;
        state_d      = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and architectural registers; reset aborts any multiply in flight
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = (state_q == ST_MUL) || (state_q == ST_ACC);
  assign Done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: doc/hilo_mult_unit.md
HILO_MULT_UNIT -- requirements
Module: hilo_mult_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO register width; all widths below are stated for the default.
REQ-002 Port: Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: Rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: Start  in  1  request strobe; sampled on the rising edge of Clk.
REQ-005 Port: Op  in  3  operation code: 000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
REQ-006 Port: A  in  32  rs operand.
REQ-007 Port: B  in  32  rt operand.
REQ-008 Port: Hi  out  32  architectural HI register, fed to the ALU Hi_in input.
REQ-009 Port: Lo  out  32  architectural LO register, fed to the ALU Lo_in input.
REQ-010 Port: Busy  out  1  high while a multiply is in flight; the pipeline stalls any HI/LO consumer on it.
REQ-011 Port: Done  out  1  one-cycle pulse; Hi and Lo already hold the new result.

Function
REQ-012 States SHALL be IDLE, MUL, ACC and DONE; Busy SHALL be 1 in MUL and ACC and 0 otherwise; Done SHALL be 1 only in DONE.
REQ-013 Start SHALL be accepted only when Busy=0 (IDLE or DONE); Start while Busy=1 SHALL be ignored with no state change.
REQ-014 MTHI/MTLO accepted at edge t: Hi (respectively Lo) := A at edge t, the state goes to IDLE, and Busy and Done stay 0.
REQ-015 MULT/MULTU/MADD/MSUB accepted at edge t SHALL latch the operands and Op, clear the 6-bit iteration counter, and enter MUL.
REQ-016 MUL SHALL perform one radix-2 shift-add step per cycle for exactly 32 cycles on the 32-bit operand magnitudes, then go to ACC.
REQ-017 Signed ops (MULT, MADD, MSUB) SHALL use |A| and |B| as unsigned 32-bit values, so -2^31 is handled; the 64-bit product SHALL be two's-complement negated when A[31]^B[31]=1.
REQ-018 In ACC, {Hi,Lo} SHALL be written at the closing edge as: product (MULT/MULTU), {Hi,Lo}+product (MADD), or {Hi,Lo}-product (MSUB); all arithmetic is modulo 2^64 and carries are discarded.
REQ-019 DONE SHALL last one cycle, then go to IDLE, or to MUL if a new multiply Start is accepted in that cycle.
REQ-020 Latency: Start accepted at edge t gives Busy=1 for 33 cycles and Done=1 in the cycle following edge t+33.
REQ-021 Reserved Op with Start SHALL be ignored: no state change and Hi/Lo unchanged.
REQ-022 Hi and Lo SHALL change only on the MTHI/MTLO acceptance edge, on the ACC closing edge, or on reset.
REQ-023 The latched operands SHALL be unaffected by changes on A, B or Op while Busy=1.

Reset
REQ-024 Rst=1 SHALL immediately force state IDLE, Hi=0, Lo=0, Busy=0, Done=0, and clear the counter and working registers, including mid-operation, which discards the result.
REQ-025 Start SHALL be ignored on any edge where Rst=1.

Structure
REQ-026 Op encodings, state encodings, and MUL_CYCLES=32 SHALL live in shared package hilo_pkg.
REQ-027 The shift-add datapath (magnitude conversion, partial product, sign fix) SHALL be one sub-module, mult_iter_dp; the FSM and HI/LO registers stay in hilo_mult_unit.

Verification
REQ-028 MULT A=7, B=FFFFFFFD -> Done 34 cycles after Start, Hi=FFFFFFFF, Lo=FFFFFFEB.
REQ-029 MULTU A=B=FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001; MULT A=B=80000000 -> Hi=40000000, Lo=00000000.
REQ-030 MTHI A=0, MTLO A=5, then MADD A=2, B=3 -> Hi=0, Lo=0000000B; then MSUB A=1, B=0000000C -> Hi=FFFFFFFF, Lo=FFFFFFFF.
REQ-031 MTHI A=12345678 pulsed during MUL cycle 5 -> ignored; the multiply result is unchanged and Busy stays high through 33 cycles.
REQ-032 Rst asserted during MUL cycle 10 -> Hi=Lo=0, Busy=0 immediately, and no Done pulse occurs.
REQ-033 Back-to-back: a second MULT Start during the DONE cycle -> accepted, and its Done arrives 34 cycles later.
